// File: rtl/cla_multiword_add_ctrl_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
// State encoding and slice width are used by the controller and the slice adder.
package cla_multiword_add_ctrl_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_multiword_add_ctrl_cla16.sv
// 16-bit two-level carry-look-ahead adder: four 4-bit groups with group P/G,
// and a look-ahead unit producing the group carries and the final carry out.
module cla_multiword_add_ctrl_cla16 (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        cin,
  output logic [15:0] out,
  output logic        cout,
  output logic        P,
  output logic        G
);

  logic [15:0] p;
  logic [15:0] g;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  gc;

  assign p = in1 ^ in2;
  assign g = in1 & in2;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_grp
      logic c1, c2, c3;
      localparam int B = 4 * gi;

      assign gp[gi] = &p[B +: 4];
      assign gg[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);

      assign c1 = g[B]   | (p[B] & gc[gi]);
      assign c2 = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
      assign c3 = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                | (p[B+2] & p[B+1] & p[B] & gc[gi]);

      assign out[B +: 4] = p[B +: 4] ^ {c3, c2, c1, gc[gi]};
    end
  endgenerate

  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  assign cout = gc[4];
  assign P    = &gp;
  assign G    = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]);

endmodule

// File: rtl/cla_multiword_add_ctrl.sv
// Wide add/subtract built by streaming 16-bit slices, LSW first, through one
// shared CLA adder with the carry registered between slices.
module cla_multiword_add_ctrl
  import cla_multiword_add_ctrl_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           sub,
  input  logic [SLICE_W*NUM_WORDS-1:0]   op_a,
  input  logic [SLICE_W*NUM_WORDS-1:0]   op_b,
  output logic                           busy,
  output logic                           done,
  output logic [SLICE_W*NUM_WORDS-1:0]   result,
  output logic                           cout,
  output logic                           overflow
);

  localparam int W     = SLICE_W * NUM_WORDS;
  localparam int IDX_W = $clog2(NUM_WORDS);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg;
  logic               carry_reg;
  logic [W-1:0]       a_reg, b_reg, result_reg;
  logic               cout_reg, ovf_reg;

  logic [SLICE_W-1:0] add_in1, add_in2, add_out;
  logic               add_cout;
  logic               grp_p_unused, grp_g_unused;
  logic               last_slice;

  assign add_in1    = a_reg[idx_reg*SLICE_W +: SLICE_W];
  assign add_in2    = b_reg[idx_reg*SLICE_W +: SLICE_W];
  assign last_slice = (idx_reg == IDX_W'(NUM_WORDS - 1));

  cla_multiword_add_ctrl_cla16 u_cla (
    .in1  (add_in1),
    .in2  (add_in2),
    .cin  (carry_reg),
    .out  (add_out),
    .cout (add_cout),
    .P    (grp_p_unused),
    .G    (grp_g_unused)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_slice) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      carry_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            // Subtract as A + ~B + 1: the +1 enters through the first slice's carry.
            a_reg     <= op_a;
            b_reg     <= sub ? ~op_b : op_b;
            carry_reg <= sub;
            idx_reg   <= '0;
          end
        end
        ST_RUN: begin
          result_reg[idx_reg*SLICE_W +: SLICE_W] <= add_out;
          carry_reg <= add_cout;
          if (last_slice) begin
            cout_reg <= add_cout;
            ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (add_out[SLICE_W-1] != a_reg[W-1]);
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_reg == ST_RUN) || (state_reg == ST_DONE);
  assign done     = (state_reg == ST_DONE);
  assign result   = result_reg;
  assign cout     = cout_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_cla_multiword_add_ctrl.sv
// Directed, table-driven bench for the 4-word (64-bit) sequencer plus
// hand-written handshake and mid-operation reset sequences.
module tb_cla_multiword_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [63:0] op_a, op_b;
  logic        busy, done, cout, overflow;
  logic [63:0] result;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        s;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  cla_multiword_add_ctrl #(.NUM_WORDS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; returns latency in cycles
  // after acceptance and whether busy stayed high throughout.
  task automatic run_op(input logic s, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    sub = s; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = ~a; op_b = ~b; sub = ~s;
    lat = 1;
    busy_ok = busy;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int          lat;
    logic        bok;
    int          dn;
    logic        after_done;

    vecs[0] = '{1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 64'h7, 64'h5, 64'h2, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, lat, bok);
      $display("op %0d: sub=%0d a=%h b=%h -> result=%h cout=%0d ovf=%0d lat=%0d",
               i, vecs[i].s, vecs[i].a, vecs[i].b, result, cout, overflow, lat);
      chk("latency", 64'(lat), 64'd5);
      chk("busy_run", bok, 1);
      chk("result", result, vecs[i].r);
      chk("cout", cout, vecs[i].co);
      chk("overflow", overflow, vecs[i].ov);
      @(negedge clk);
      chk("busy_idle", busy, 0);
    end

    // Handshake: extra starts during RUN and in the done cycle, op_a changed mid-RUN.
    @(negedge clk);
    sub = 1'b0; op_a = 64'h10; op_b = 64'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dn = 0; after_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (after_done) begin
        chk("hs_idle_after_done", busy, 0);
        after_done = 1'b0;
      end
      if (done) begin
        dn++;
        if (dn == 1) begin
          chk("hs_result", result, 64'h30);
          start = 1'b1;
          after_done = 1'b1;
        end
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    $display("handshake: done pulses=%0d result=%h", dn, result);
    chk("hs_done_count", 64'(dn), 64'd1);
    run_op(1'b0, 64'h100, 64'h23, lat, bok);
    $display("post-handshake op: result=%h lat=%0d", result, lat);
    chk("hs_next_lat", 64'(lat), 64'd5);
    chk("hs_next_result", result, 64'h123);

    // Leave cout/overflow set, then abort an operation two cycles into RUN.
    run_op(1'b1, 64'h8000_0000_0000_0000, 64'h1, lat, bok);
    chk("pre_abort_ovf", overflow, 1);
    @(negedge clk);
    sub = 1'b0; op_a = 64'h1111_1111_1111_1111; op_b = 64'h1111_1111_1111_1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("abort: busy=%0d done=%0d result=%h cout=%0d ovf=%0d",
             busy, done, result, cout, overflow);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_cout", cout, 0);
    chk("abort_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, lat, bok);
    $display("post-reset op: result=%h lat=%0d", result, lat);
    chk("post_rst_lat", 64'(lat), 64'd5);
    chk("post_rst_result", result, 64'h2222_2222_2222_2222);
    chk("post_rst_cout", cout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla_multiword_add_ctrl.md
Name: cla_multiword_add_ctrl

Overview:
- Sequencer that performs NUM_WORDS×16-bit add/subtract by streaming 16-bit slices, LSW first, through one shared 16-bit carry-look-ahead adder instance.
- Carry is registered between slices; one slice per clock.
- Sits between a requester (start/done handshake) and the 16-bit CLA datapath. Lets wide operands reuse the existing adder instead of a wide combinational chain.

Parameters:
- NUM_WORDS, 4, number of 16-bit slices; operand width W = 16*NUM_WORDS (default 64). Legal range 2..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- sub  in  1  0 = A+B, 1 = A−B; sampled with start.
- op_a  in  W  operand A; sampled with start.
- op_b  in  W  operand B; sampled with start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse: result valid.
- result  out  W  sum/difference; held until the next accepted start.
- cout  out  1  final carry out of the MSW (for sub: 1 = no borrow).
- overflow  out  1  two's-complement signed overflow of the W-bit operation.

Behaviour:
- Reset (async assert, sync release) clears state to IDLE, slice index to 0, carry reg to 0, and A/B regs to 0. Outputs reset to: busy=0, done=0, result=0, cout=0, overflow=0.
- FSM states:
  - IDLE: if start=1, latch op_a into A reg, latch (sub ? ~op_b : op_b) into B reg, set carry reg = sub, set idx = 0, go to RUN. Otherwise stay.
  - RUN: the adder sees A[16*idx+:16], B[16*idx+:16], and carry reg as cin. At each edge:
    - result[16*idx+:16] ← adder out; carry reg ← adder cout; idx ← idx+1.
    - When idx = NUM_WORDS−1, also capture cout and overflow, then go to DONE.
  - DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency: start accepted at edge t0. RUN occupies the NUM_WORDS cycles after t0. done is high in cycle NUM_WORDS+1 after t0. Throughput is one operation per NUM_WORDS+2 cycles.
- start is ignored in RUN and DONE; no queueing, no error flag. start in the same cycle done is high is ignored.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- result slices update progressively during RUN. Consumers use result only at/after done. result is stable from the done cycle until the next accepted start.
- overflow = (A[W−1] == Beff[W−1]) && (sum[W−1] != A[W−1]), where Beff is the latched (possibly inverted) B.
- cout is the carry out of the top slice. For sub, cout=1 ⇔ A ≥ B unsigned.
- The adder's group P/G outputs are unused; cin for the first slice comes from the carry reg, never tied.
- idx width = clog2(NUM_WORDS); it never wraps past NUM_WORDS−1.
- Reset asserted mid-RUN aborts the operation immediately. No done is issued; all outputs return to reset values.

Decomposition:
- Shared package: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; SLICE_W=16.
- One sub-module: the existing 16-bit CLA adder (in1, in2, cin, out, cout, P, G), instantiated once as the slice datapath.
- Controller FSM, slice mux and result demux stay in this module.

Test Plan:
- NUM_WORDS=4, reset then start, sub=0, A=64'h0000_0000_0000_FFFF, B=64'h1 → done at cycle 5 after acceptance; result=64'h0000_0000_0001_0000, cout=0, overflow=0; busy high cycles 1–5.
- Full carry ripple across all slices: sub=0, A=64'hFFFF_FFFF_FFFF_FFFF, B=64'h1 → result=0, cout=1, overflow=0.
- Subtract with borrow: sub=1, A=64'h5, B=64'h7 → result=64'hFFFF_FFFF_FFFF_FFFE, cout=0; then A=64'h7, B=64'h5 → result=64'h2, cout=1.
- Signed overflow: sub=0, A=64'h7FFF_FFFF_FFFF_FFFF, B=64'h1 → result=64'h8000_0000_0000_0000, overflow=1; and sub=1, A=64'h8000_0000_0000_0000, B=64'h1 → overflow=1.
- Handshake: pulse start again during RUN and during the done cycle, and change op_a mid-RUN → only one done; result matches the first operands; the next start is accepted in IDLE.
- Reset mid-op: assert rst_n=0 two cycles into RUN → busy, done, result, cout, overflow go to 0 asynchronously. After release, a new start completes correctly.
